flood_reveal: RTL and testbench

//  Consumer of the neighbour-count array: on a player click, reveals the clicked field
//  and flood-fills every field reachable through revealed zero-count fields.

---
 rtl/flood_reveal.sv | 198 +++++++++++++++++++
 tb/tb_flood_reveal.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flood_reveal.sv
`default_nettype none
// ============================================================================
// Module      : flood_reveal
// Description : Reveals a clicked field and flood-fills through zero-count
//               fields with a repeated raster sweep, one cell per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module flood_reveal #(
  parameter int SIZE_EASY   = 8,
  parameter int SIZE_MEDIUM = 10,
  parameter int SIZE_HARD   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             level,
  input  logic                   new_game,
  input  logic                   start,
  input  logic [3:0]             click_x,
  input  logic [3:0]             click_y,
  input  logic                   explode,
  input  logic [15:0][15:0]      mine_arr,
  input  logic [15:0][15:0][2:0] num_arr,
  output logic [15:0][15:0]      reveal_arr,
  output logic                   busy,
  output logic                   done
);

  localparam logic [4:0] c_n_easy   = 5'(SIZE_EASY);
  localparam logic [4:0] c_n_medium = 5'(SIZE_MEDIUM);
  localparam logic [4:0] c_n_hard   = 5'(SIZE_HARD);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEED     = 3'd1,
    S_SCAN     = 3'd2,
    S_PASS_END = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state;
  logic [3:0]  r_x;
  logic [3:0]  r_y;
  logic [3:0]  r_cx;
  logic [3:0]  r_cy;
  logic [1:0]  r_level;
  logic        r_changed;

  logic [4:0]  w_n_req;
  logic [4:0]  w_n;
  logic [3:0]  w_xm, w_xp, w_ym, w_yp;
  logic        w_vxm, w_vxp, w_vym, w_vyp;
  logic        w_nb;
  logic        w_set;
  logic        w_last_x;
  logic        w_last_y;
  logic        w_accept;
  logic        w_abort;
  logic [15:0][15:0] w_src;

  function automatic logic [4:0] edge_of(input logic [1:0] lv);
    case (lv)
      2'd1:    return c_n_easy;
      2'd2:    return c_n_medium;
      2'd3:    return c_n_hard;
      default: return 5'd0;
    endcase
  endfunction

  // Request size follows the live level; the sweep uses the level latched at accept.
  assign w_n_req = edge_of(level);
  assign w_n     = edge_of(r_level);

  // A cell can spread the flood when it is revealed, not a mine and has count 0
  // (a wrapped count of 8 also reads as 0; the mine term keeps mines out).
  for (genvar gx = 0; gx < 16; gx++) begin : g_src_x
    for (genvar gy = 0; gy < 16; gy++) begin : g_src_y
      assign w_src[gx][gy] = reveal_arr[gx][gy] & ~mine_arr[gx][gy] &
                             (num_arr[gx][gy] == 3'd0);
    end
  end

  assign w_xm  = r_x - 4'd1;
  assign w_xp  = r_x + 4'd1;
  assign w_ym  = r_y - 4'd1;
  assign w_yp  = r_y + 4'd1;
  assign w_vxm = (r_x != 4'd0);
  assign w_vym = (r_y != 4'd0);
  assign w_vxp = (({1'b0, r_x} + 5'd1) < w_n);
  assign w_vyp = (({1'b0, r_y} + 5'd1) < w_n);

  // Validity flags stop the 4-bit neighbour indices from wrapping across edges.
  assign w_nb = (w_vxm & w_vym & w_src[w_xm][w_ym]) |
                (        w_vym & w_src[r_x ][w_ym]) |
                (w_vxp & w_vym & w_src[w_xp][w_ym]) |
                (w_vxm &         w_src[w_xm][r_y ]) |
                (w_vxp &         w_src[w_xp][r_y ]) |
                (w_vxm & w_vyp & w_src[w_xm][w_yp]) |
                (        w_vyp & w_src[r_x ][w_yp]) |
                (w_vxp & w_vyp & w_src[w_xp][w_yp]);

  assign w_set    = ~reveal_arr[r_x][r_y] & ~mine_arr[r_x][r_y] & w_nb;
  assign w_last_x = ({1'b0, r_x} == (w_n - 5'd1));
  assign w_last_y = ({1'b0, r_y} == (w_n - 5'd1));

  assign w_accept = start && (level != 2'd0) &&
                    ({1'b0, click_x} < w_n_req) && ({1'b0, click_y} < w_n_req);
  assign w_abort  = (r_state != S_IDLE) && (level != r_level);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_cx       <= 4'd0;
      r_cy       <= 4'd0;
      r_level    <= 2'd0;
      r_changed  <= 1'b0;
      reveal_arr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (new_game) begin
      r_state    <= S_IDLE;
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_changed  <= 1'b0;
      reveal_arr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (explode || w_abort) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cx    <= click_x;
            r_cy    <= click_y;
            r_level <= level;
            busy    <= 1'b1;
            r_state <= S_SEED;
          end
        end
        S_SEED: begin
          if (mine_arr[r_cx][r_cy]) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            reveal_arr[r_cx][r_cy] <= 1'b1;
            r_x       <= 4'd0;
            r_y       <= 4'd0;
            r_changed <= 1'b0;
            r_state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_set) begin
            reveal_arr[r_x][r_y] <= 1'b1;
            r_changed            <= 1'b1;
          end
          if (w_last_x) begin
            r_x <= 4'd0;
            if (w_last_y) begin
              r_y     <= 4'd0;
              r_state <= S_PASS_END;
            end else begin
              r_y <= r_y + 4'd1;
            end
          end else begin
            r_x <= r_x + 4'd1;
          end
        end
        S_PASS_END: begin
          if (r_changed) begin
            r_changed <= 1'b0;
            r_x       <= 4'd0;
            r_y       <= 4'd0;
            r_state   <= S_SCAN;
          end else begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flood_reveal.sv
`default_nettype none
// ============================================================================
// Module      : tb_flood_reveal
// Description : Self-checking bench for flood_reveal against a fixpoint model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flood_reveal;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             level;
  logic                   new_game;
  logic                   start;
  logic [3:0]             click_x;
  logic [3:0]             click_y;
  logic                   explode;
  logic [15:0][15:0]      mine_arr;
  logic [15:0][15:0][2:0] num_arr;
  logic [15:0][15:0]      reveal_arr;
  logic                   busy;
  logic                   done;

  int n_tests = 0;
  int n_fail  = 0;

  bit       m_mine [16][16];
  bit [2:0] m_num  [16][16];
  bit       m_rev  [16][16];

  always #5 clk = ~clk;

  flood_reveal #(.SIZE_EASY(8), .SIZE_MEDIUM(10), .SIZE_HARD(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .level      (level),
    .new_game   (new_game),
    .start      (start),
    .click_x    (click_x),
    .click_y    (click_y),
    .explode    (explode),
    .mine_arr   (mine_arr),
    .num_arr    (num_arr),
    .reveal_arr (reveal_arr),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(int lv);
    case (lv)
      1: return 8;
      2: return 10;
      3: return 16;
      default: return 0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic bit is_src(int n, int x, int y);
    if (x < 0 || y < 0 || x >= n || y >= n) return 1'b0;
    return m_rev[x][y] && !m_mine[x][y] && (m_num[x][y] == 3'd0);
  endfunction

  // Repeats raster passes with immediate updates until a pass changes nothing;
  // returns the click-to-done latency in clocks.
  task automatic model_click(int n, int cx, int cy, output int lat);
    int  passes;
    bit  chg;
    bit  any;
    if (m_mine[cx][cy]) begin
      lat = 2;
      return;
    end
    m_rev[cx][cy] = 1'b1;
    passes = 0;
    do begin
      chg = 1'b0;
      for (int y = 0; y < n; y++) begin
        for (int x = 0; x < n; x++) begin
          if (!m_rev[x][y] && !m_mine[x][y]) begin
            any = 1'b0;
            for (int dy = -1; dy <= 1; dy++)
              for (int dx = -1; dx <= 1; dx++)
                if ((dx != 0 || dy != 0) && is_src(n, x + dx, y + dy)) any = 1'b1;
            if (any) begin
              m_rev[x][y] = 1'b1;
              chg = 1'b1;
            end
          end
        end
      end
      passes++;
    end while (chg);
    lat = 2 + passes * (n * n + 1);
  endtask

  task automatic clear_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        m_mine[x][y] = 1'b0;
        m_num[x][y]  = 3'd0;
      end
  endtask

  // Counts are taken modulo 8; cells outside the board get junk that must be ignored.
  task automatic build_nums(int n);
    int c;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        if (x >= n || y >= n) begin
          m_num[x][y] = 3'($urandom_range(0, 7));
        end else begin
          c = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if ((dx != 0 || dy != 0) && x + dx >= 0 && y + dy >= 0 &&
                  x + dx < n && y + dy < n && m_mine[x + dx][y + dy])
                c++;
          m_num[x][y] = 3'(c);
        end
      end
  endtask

  task automatic load_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        mine_arr[x][y] = m_mine[x][y];
        num_arr[x][y]  = m_num[x][y];
      end
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) m_rev[x][y] = 1'b0;
  endtask

  task automatic check_reveal(string name);
    int mism = 0;
    int fx = 0;
    int fy = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        if (reveal_arr[x][y] !== m_rev[x][y]) begin
          if (mism == 0) begin fx = x; fy = y; end
          mism++;
        end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL %s reveal: %0d cells differ, first (%0d,%0d) got %0b expected %0b",
               name, mism, fx, fy, reveal_arr[fx][fy], m_rev[fx][fy]);
    end
  endtask

  // Click with optional intruding start pulse at cycle ik (0 = none).
  task automatic do_click(string name, int lv, int cx, int cy, int ik, int ix, int iy);
    int exp_lat;
    int k;
    model_click(size_of(lv), cx, cy, exp_lat);
    level   = 2'(lv);
    click_x = 4'(cx);
    click_y = 4'(cy);
    start   = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_rise: got %b expected 1", name, busy);
    end
    while (done !== 1'b1 && k < 40000) begin
      if (k == ik) begin
        start   = 1'b1;
        click_x = 4'(ix);
        click_y = 4'(iy);
      end
      tick();
      start = 1'b0;
      k++;
    end
    n_tests++;
    if (done !== 1'b1 || k != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: done=%b after %0d clks, expected done after %0d",
               name, done, k, exp_lat);
    end
    check_reveal(name);
    tick();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: busy=%b done=%b expected 0/0", name, busy, done);
    end
  endtask

  task automatic expect_no_busy(string name, int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s: busy/done observed high, expected both 0", name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; level = 2'd0; new_game = 1'b0; start = 1'b0; explode = 1'b0;
    click_x = 4'd0; click_y = 4'd0;
    clear_board();
    load_board();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) m_rev[x][y] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b expected 0/0", busy, done);
    end
    check_reveal("reset");
    click_x = 4'd1; click_y = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    expect_no_busy("level0_start", 4);
  endtask

  task automatic test_easy_empty();
    clear_board();
    load_board();
    do_new_game();
    do_click("easy_empty", 1, 3, 4, 0, 0, 0);
  endtask

  task automatic test_easy_corner_mine();
    clear_board();
    m_mine[0][0] = 1'b1;
    m_num[1][0] = 3'd1; m_num[0][1] = 3'd1; m_num[1][1] = 3'd1;
    load_board();
    do_new_game();
    do_click("easy_corner", 1, 7, 7, 0, 0, 0);
    n_tests++;
    if (reveal_arr[0][0] !== 1'b0) begin
      n_fail++;
      $display("FAIL easy_corner mine_cell: got %b expected 0", reveal_arr[0][0]);
    end
  endtask

  task automatic test_medium_mine_click();
    clear_board();
    m_mine[2][2] = 1'b1;
    for (int y = 0; y < 10; y++) m_mine[4][y] = 1'b1;
    build_nums(10);
    load_board();
    do_new_game();
    do_click("medium_prefill", 2, 8, 8, 0, 0, 0);
    do_click("medium_mine", 2, 2, 2, 0, 0, 0);
  endtask

  task automatic test_hard_edge();
    int cnt = 0;
    clear_board();
    m_num[14][0] = 3'd2; m_num[14][1] = 3'd2; m_num[15][1] = 3'd2;
    load_board();
    do_new_game();
    do_click("hard_edge", 3, 15, 0, 0, 0, 0);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) cnt += int'(reveal_arr[x][y]);
    n_tests++;
    if (cnt != 4 || reveal_arr[0][0] !== 1'b0 || reveal_arr[15][15] !== 1'b0) begin
      n_fail++;
      $display("FAIL hard_edge count: got %0d revealed, (0,0)=%b (15,15)=%b expected 4,0,0",
               cnt, reveal_arr[0][0], reveal_arr[15][15]);
    end
  endtask

  task automatic test_wrapped_count();
    clear_board();
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) m_mine[3 + dx][3 + dy] = 1'b1;
    build_nums(8);
    load_board();
    do_new_game();
    do_click("wrap8", 1, 3, 3, 0, 0, 0);
  endtask

  task automatic test_busy_start_ignored();
    clear_board();
    for (int y = 0; y < 8; y++) m_mine[4][y] = 1'b1;
    build_nums(8);
    load_board();
    do_new_game();
    do_click("busy_start", 1, 0, 0, 5, 7, 7);
  endtask

  task automatic test_explode_abort();
    bit saw_done = 1'b0;
    clear_board();
    load_board();
    do_new_game();
    level = 2'd3; click_x = 4'd5; click_y = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    explode = 1'b1;
    tick();
    explode = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL explode_flags: busy=%b done=%b expected 0/0", busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL explode_quiet: busy/done rose after explode, expected 0");
    end
    m_rev[5][5] = 1'b1;
    check_reveal("explode_hold");
    // new_game wins over a simultaneous start
    new_game = 1'b1; start = 1'b1; click_x = 4'd2; click_y = 4'd2;
    tick();
    new_game = 1'b0; start = 1'b0;
    m_rev[5][5] = 1'b0;
    expect_no_busy("newgame_priority", 4);
    check_reveal("newgame_clear");
    level = 2'd1; click_x = 4'd8; click_y = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    expect_no_busy("easy_x_out_of_range", 4);
    level = 2'd2; click_x = 4'd3; click_y = 4'd10; start = 1'b1;
    tick();
    start = 1'b0;
    expect_no_busy("medium_y_out_of_range", 4);
    check_reveal("out_of_range_nochange");
  endtask

  task automatic test_level_change();
    bit seen = 1'b0;
    clear_board();
    load_board();
    do_new_game();
    level = 2'd2; click_x = 4'd4; click_y = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    level = 2'd3;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL level_abort busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL level_abort done: done pulsed, expected none");
    end
    m_rev[4][4] = 1'b1;
    check_reveal("level_abort");
  endtask

  task automatic test_random();
    int lv;
    int n;
    int dens;
    for (int g = 0; g < 5; g++) begin
      lv   = int'($urandom_range(1, 3));
      n    = size_of(lv);
      dens = int'($urandom_range(5, 25));
      clear_board();
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          m_mine[x][y] = ($urandom_range(0, 99) < dens);
      build_nums(n);
      load_board();
      do_new_game();
      for (int c = 0; c < 3; c++)
        do_click($sformatf("random_g%0d_c%0d", g, c), lv,
                 int'($urandom_range(0, n - 1)), int'($urandom_range(0, n - 1)), 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_easy_empty();
    test_easy_corner_mine();
    test_medium_mine_click();
    test_hard_edge();
    test_wrapped_count();
    test_busy_start_ignored();
    test_explode_abort();
    test_level_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
